mux_pipe_reg: RTL and testbench

- Parametrised N-input, W-bit selector fused with a pipeline register, with stall (hold) and flush (bubble) control.
- Replaces the "two-input select, then separate stage register" pattern at the inter-stage boundaries of the pipelined CPU: IF/ID, ID/EX, EX/MEM and MEM/WB operand and forward paths.
- Output is registered: the selected operand appears one cycle after capture.

---
 rtl/mux_pipe_reg_pkg.sv | 25 ++
 rtl/mux_pipe_reg_mux_n.sv | 36 +++
 rtl/mux_pipe_reg.sv | 108 ++++++++++
 tb/tb_mux_pipe_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pipe_reg_pkg
//  Purpose  : Constants and helpers shared by the fused selector/stage
//             register used at the CPU inter-stage boundaries.
//  Contents : MUX_PIPE_REG_MAX_IN - largest supported selector fan-in
//             WORD, REG_IDX       - standard stage widths for WIDTH overrides
//             sel_fits()          - parameter legality check
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pipe_reg_pkg;

  localparam int MUX_PIPE_REG_MAX_IN = 16;
  localparam int WORD                = 32;
  localparam int REG_IDX             = 5;

  // True when a SEL_W-bit select can address num_in inputs and num_in is in
  // the supported range.
  function automatic bit sel_fits(input int num_in, input int sel_w);
    return (num_in >= 2) && (num_in <= MUX_PIPE_REG_MAX_IN) &&
           ((64'd1 << sel_w) >= 64'(num_in));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_pipe_reg_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : mux_n
//  Purpose  : Purely combinational N-way, WIDTH-bit selector. A select value
//             that does not address an existing input returns input 0.
//  Ports    : in_bus  [NUM_IN*WIDTH] concatenated inputs, input k at
//                     [k*WIDTH +: WIDTH]
//             sel     [SEL_W]        input index
//             out     [WIDTH]        selected input
//  Revision : 1.0 - initial release
// ============================================================================
module mux_n
  import mux_pipe_reg_pkg::*;
#(
  parameter int WIDTH  = WORD,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out
);

  // Input 0 is the default, so any unmatched select falls back to it
  // without a separate range comparator.
  always_comb begin
    out = in_bus[0 +: WIDTH];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pipe_reg
//  Purpose  : N-input selector fused with a pipeline stage register, with
//             stall (hold) and flush (bubble) control. Output is registered;
//             priority at the clock edge is reset > flush > stall > load.
//  Ports    : clk, reset (async, active-high)
//             in_bus [NUM_IN*WIDTH], sel [SEL_W], in_valid, stall, flush
//             data_out [WIDTH], valid_out, sel_out [SEL_W], sel_err
//  Options  : MUX_PIPE_REG_SEL_ERR_EN - when defined, sel_err is a sticky
//             flag set by any load with sel >= NUM_IN (cleared only by
//             reset). When undefined, sel_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_pipe_reg
  import mux_pipe_reg_pkg::*;
#(
  parameter int               WIDTH   = WORD,
  parameter int               NUM_IN  = 4,
  parameter int               SEL_W   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        data_out,
  output logic                    valid_out,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    sel_err
);

  generate
    if (!sel_fits(NUM_IN, SEL_W)) begin : g_param_err
      $error("mux_pipe_reg: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
    end
  endgenerate

  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic             w_load;

  assign w_load = !flush && !stall;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_bus (in_bus),
    .sel    (sel),
    .out    (w_sel_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= RST_VAL;
      r_valid <= 1'b0;
      r_sel   <= '0;
    end else if (flush) begin
      r_data  <= RST_VAL;
      r_valid <= 1'b0;
      r_sel   <= '0;
    end else if (!stall) begin
      r_data  <= w_sel_data;
      r_valid <= in_valid;
      // Raw select is kept even when out of range so downstream forwarding
      // checks see what was actually requested.
      r_sel   <= sel;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign sel_out   = r_sel;

`ifdef MUX_PIPE_REG_SEL_ERR_EN
  logic w_sel_oob;
  logic r_sel_err;

  assign w_sel_oob = (32'(sel) >= NUM_IN);

  // Sticky: only reset clears it, a flush must not hide a past bad select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_load && w_sel_oob) begin
      r_sel_err <= 1'b1;
`ifndef SYNTHESIS
      if (!r_sel_err) begin
        $display("%0t mux_pipe_reg warning: out-of-range sel %0d", $time, sel);
      end
`endif
    end
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_pipe_reg
//  Purpose  : Directed self-checking bench for mux_pipe_reg using three
//             instances (NUM_IN = 4, 3, 2) sharing one set of stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_pipe_reg;

`ifdef MUX_PIPE_REG_SEL_ERR_EN
  localparam logic c_exp_err = 1'b1;
`else
  localparam logic c_exp_err = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [127:0] in_bus;
  logic [1:0]   sel;
  logic         in_valid;
  logic         stall;
  logic         flush;

  logic [31:0]  data4, data3, data2;
  logic         valid4, valid3, valid2;
  logic [1:0]   sel_out4, sel_out3;
  logic [0:0]   sel_out2;
  logic         err4, err3, err2;

  int n_tests;
  int n_fail;

  mux_pipe_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .RST_VAL(32'h0)) u_dut4 (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .data_out(data4), .valid_out(valid4),
    .sel_out(sel_out4), .sel_err(err4)
  );

  mux_pipe_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .RST_VAL(32'h0)) u_dut3 (
    .clk(clk), .reset(reset), .in_bus(in_bus[95:0]), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .data_out(data3), .valid_out(valid3),
    .sel_out(sel_out3), .sel_err(err3)
  );

  mux_pipe_reg #(.WIDTH(32), .NUM_IN(2), .SEL_W(1), .RST_VAL(32'h0)) u_dut2 (
    .clk(clk), .reset(reset), .in_bus(in_bus[63:0]), .sel(sel[0:0]), .in_valid(in_valid),
    .stall(stall), .flush(flush), .data_out(data2), .valid_out(valid2),
    .sel_out(sel_out2), .sel_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] c_vec = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

  logic [31:0] m_data;
  logic        m_valid;
  logic        m_sel;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_bus   = c_vec;
    sel      = 2'd0;
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    step();
    step();
    chk("rst_data", data4, 32'h0);
    chk("rst_valid", valid4, 1'b0);
    chk("rst_sel", sel_out4, 2'd0);
    chk("rst_err3", err3, 1'b0);

    // Load something non-zero, then reset between edges.
    reset    = 1'b0;
    sel      = 2'd1;
    in_valid = 1'b1;
    step();
    chk("pre_load", data4, 32'hBBBB0001);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data", data4, 32'h0);
    chk("async_rst_valid", valid4, 1'b0);
    #1 reset = 1'b0;

    sel = 2'd2;
    step();
    chk("load_data", data4, 32'hCCCC0002);
    chk("load_valid", valid4, 1'b1);
    chk("load_sel", sel_out4, 2'd2);

    // Stall for three cycles while the inputs move.
    stall = 1'b1;
    sel   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_bus = {4{32'h5A5A0000 + 32'(i)}};
      in_valid = 1'b0;
      step();
      chk("stall_data", data4, 32'hCCCC0002);
      chk("stall_valid", valid4, 1'b1);
    end
    in_bus   = c_vec;
    in_valid = 1'b1;
    stall    = 1'b0;
    step();
    chk("unstall_data", data4, 32'hAAAA0000);
    chk("unstall_sel", sel_out4, 2'd0);

    // Load with an invalid (bubble) marker.
    sel      = 2'd3;
    in_valid = 1'b0;
    step();
    chk("bubble_data", data4, 32'hDDDD0003);
    chk("bubble_valid", valid4, 1'b0);
    chk("oob_data3", data3, 32'hAAAA0000);
    chk("oob_sel3", sel_out3, 2'd3);
    chk("oob_err3", err3, c_exp_err);
    chk("inrange_err4", err4, 1'b0);

    // Flush beats stall.
    sel      = 2'd1;
    in_valid = 1'b1;
    flush    = 1'b1;
    stall    = 1'b1;
    step();
    chk("flush_data", data4, 32'h0);
    chk("flush_valid", valid4, 1'b0);
    chk("flush_sel", sel_out4, 2'd0);
    chk("flush_err3", err3, c_exp_err);

    // Async reset while stalled.
    flush            = 1'b0;
    stall            = 1'b0;
    in_bus[31:0]     = 32'h12345678;
    sel              = 2'd0;
    step();
    chk("pre_stall_data", data4, 32'h12345678);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("stall_rst_data", data4, 32'h0);
    chk("stall_rst_err3", err3, 1'b0);
    #1 reset = 1'b0;
    step();
    chk("stall_rst_hold1", data4, 32'h0);
    step();
    chk("stall_rst_hold2", data4, 32'h0);
    chk("stall_rst_valid", valid4, 1'b0);

    // Two-input equivalence against a select + register model.
    stall   = 1'b0;
    m_data  = 32'h0;
    m_valid = 1'b0;
    m_sel   = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      in_bus   = {$urandom, $urandom, $urandom, $urandom};
      sel      = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      if (flush) begin
        m_data  = 32'h0;
        m_valid = 1'b0;
        m_sel   = 1'b0;
      end else if (!stall) begin
        m_data  = sel[0] ? in_bus[63:32] : in_bus[31:0];
        m_valid = in_valid;
        m_sel   = sel[0];
      end
      step();
      chk("eq2_data", data2, m_data);
      chk("eq2_valid", valid2, m_valid);
      chk("eq2_sel", sel_out2, m_sel);
    end
    chk("eq2_err", err2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
